// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_pkg
//  Purpose  : Shared types and constants for the fetch unit: bundle geometry,
//             address width, reset vector and the fetch state encoding.
//  Revision : 1.0  initial release
// ============================================================================
package fetch_pkg;

    localparam int INSTRUCTION_WIDTH       = 32;
    localparam int INSTRUCTIONS_PER_BUNDLE = 4;
    localparam int BUNDLE_WIDTH            = INSTRUCTION_WIDTH * INSTRUCTIONS_PER_BUNDLE;
    localparam int ADDRESS_WIDTH           = 64;
    localparam int BUNDLE_BYTES            = 16;
    localparam int FETCH_UNIT_INSTANCE     = 0;

    localparam logic [0:ADDRESS_WIDTH-1] RESET_VECTOR = 64'h100;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQ     = 3'd1,
        S_WAIT    = 3'd2,
        S_HOLD    = 3'd3,
        S_DISCARD = 3'd4
    } fetch_state_e;

    // Addresses use big-endian bit numbering: bit 0 is the MSB, so the low
    // four byte-offset bits are [ADDRESS_WIDTH-4 : ADDRESS_WIDTH-1].
    function automatic logic [0:ADDRESS_WIDTH-1] align_bundle(
        input logic [0:ADDRESS_WIDTH-1] addr
    );
        return addr & ~64'(BUNDLE_BYTES - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_if.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_if
//  Purpose  : Bundles the fetch unit's back-end redirect, I-cache request /
//             response and fetch-queue write signals.
//  Ports    : master modport = fetch unit side, slave modport = environment
//             (back end, I-cache and fetch queue).
//  Revision : 1.0  initial release
// ============================================================================
interface fetch_if;
    import fetch_pkg::*;

    // Back-end redirect
    logic                        redirect_i;
    logic [0:ADDRESS_WIDTH-1]    redirectAddress_i;
    // I-cache request / response
    logic                        icacheReq_o;
    logic [0:ADDRESS_WIDTH-1]    icacheAddress_o;
    logic                        icacheReady_i;
    logic                        icacheValid_i;
    logic [0:BUNDLE_WIDTH-1]     icacheBundle_i;
    // Fetch queue
    logic                        queueFull_i;
    logic                        bundleWrite_o;
    logic [0:BUNDLE_WIDTH-1]     bundle_o;
    // Debug / next-fetch address
    logic [0:ADDRESS_WIDTH-1]    pc_o;

    modport master (
        input  redirect_i, redirectAddress_i,
        input  icacheReady_i, icacheValid_i, icacheBundle_i,
        input  queueFull_i,
        output icacheReq_o, icacheAddress_o,
        output bundleWrite_o, bundle_o, pc_o
    );

    modport slave (
        output redirect_i, redirectAddress_i,
        output icacheReady_i, icacheValid_i, icacheBundle_i,
        output queueFull_i,
        input  icacheReq_o, icacheAddress_o,
        input  bundleWrite_o, bundle_o, pc_o
    );

endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Purpose  : Producer side of the fetch queue. Owns the fetch PC, issues one
//             bundle-aligned request at a time to the L1 I-cache, writes each
//             returned 4-instruction bundle into the fetch queue (stalling in
//             a hold register while the queue is full) and handles redirects,
//             discarding any stale in-flight response.
//  Ports    : clock_i  - clock
//             reset_i  - synchronous active-high reset
//             bus      - fetch_if.master (redirect, I-cache, queue, pc_o)
//  Revision : 1.0  initial release
// ============================================================================
module fetch_unit
    import fetch_pkg::*;
(
    input  wire        clock_i,
    input  wire        reset_i,
    fetch_if.master    bus
);

    fetch_state_e                r_state_q, w_state_d;
    logic [0:ADDRESS_WIDTH-1]    r_pc_q,    w_pc_d;
    logic [0:BUNDLE_WIDTH-1]     r_hold_q,  w_hold_d;
    logic [0:BUNDLE_WIDTH-1]     r_bundle_q, w_bundle_d;
    logic                        r_write_q, w_write_d;

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_state_q  <= S_IDLE;
            r_pc_q     <= RESET_VECTOR;
            r_hold_q   <= '0;
            r_bundle_q <= '0;
            r_write_q  <= 1'b0;
        end else begin
            r_state_q  <= w_state_d;
            r_pc_q     <= w_pc_d;
            r_hold_q   <= w_hold_d;
            r_bundle_q <= w_bundle_d;
            r_write_q  <= w_write_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic. Redirect outranks everything and never writes.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_d  = r_state_q;
        w_pc_d     = r_pc_q;
        w_hold_d   = r_hold_q;
        w_bundle_d = r_bundle_q;
        w_write_d  = 1'b0;

        if (bus.redirect_i) begin
            w_pc_d = align_bundle(bus.redirectAddress_i);
            unique case (r_state_q)
                // A request is in flight: its response must be swallowed
                // unless it is arriving right now.
                S_WAIT, S_DISCARD: w_state_d = bus.icacheValid_i ? S_REQ : S_DISCARD;
                default:           w_state_d = S_REQ;
            endcase
        end else begin
            unique case (r_state_q)
                S_IDLE: w_state_d = S_REQ;
                S_REQ: begin
                    if (bus.icacheReady_i) begin
                        w_state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.icacheValid_i) begin
                        if (bus.queueFull_i) begin
                            w_hold_d  = bus.icacheBundle_i;
                            w_state_d = S_HOLD;
                        end else begin
                            w_bundle_d = bus.icacheBundle_i;
                            w_write_d  = 1'b1;
                            w_pc_d     = r_pc_q + 64'(BUNDLE_BYTES);
                            w_state_d  = S_REQ;
                        end
                    end
                end
                S_HOLD: begin
                    if (!bus.queueFull_i) begin
                        w_bundle_d = r_hold_q;
                        w_write_d  = 1'b1;
                        w_pc_d     = r_pc_q + 64'(BUNDLE_BYTES);
                        w_state_d  = S_REQ;
                    end
                end
                S_DISCARD: begin
                    if (bus.icacheValid_i) begin
                        w_state_d = S_REQ;
                    end
                end
                default: w_state_d = S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs, all decoded from registered state
    // ------------------------------------------------------------------------
    assign bus.icacheReq_o     = (r_state_q == S_REQ);
    assign bus.icacheAddress_o = align_bundle(r_pc_q);
    assign bus.bundleWrite_o   = r_write_q;
    assign bus.bundle_o        = r_bundle_q;
    assign bus.pc_o            = r_pc_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_unit
//  Purpose  : Scoreboard bench for fetch_unit. Directed stimulus pushes the
//             expected queue writes and I-cache request addresses; a monitor
//             on the falling edge pops and compares them.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_unit;
    import fetch_pkg::*;

    typedef logic [0:BUNDLE_WIDTH-1]  bundle_t;
    typedef logic [0:ADDRESS_WIDTH-1] addr_t;
    typedef struct {
        bundle_t data;
        addr_t   pc;
    } wr_t;

    logic clock_i = 1'b0;
    logic reset_i = 1'b1;
    always #5 clock_i = ~clock_i;

    fetch_if bus();

    fetch_unit dut (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .bus     (bus)
    );

    wr_t   exp_wr[$];
    addr_t exp_req[$];
    wr_t   mon_wr;
    addr_t mon_req;
    int    total = 0;
    int    bad   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------------
    // Monitor: compares every queue write and every accepted request
    // ------------------------------------------------------------------------
    always @(negedge clock_i) begin
        if (!reset_i) begin
            if (bus.bundleWrite_o) begin
                if (exp_wr.size() == 0) begin
                    chk("unexpected_write", 128'd1, 128'd0);
                end else begin
                    mon_wr = exp_wr.pop_front();
                    chk("bundle", bus.bundle_o, mon_wr.data);
                    chk("pc_after_write", 128'(bus.pc_o), 128'(mon_wr.pc));
                end
            end
            if (bus.icacheReq_o && bus.icacheReady_i) begin
                if (exp_req.size() == 0) begin
                    chk("unexpected_req", 128'd1, 128'd0);
                end else begin
                    mon_req = exp_req.pop_front();
                    chk("req_addr", 128'(bus.icacheAddress_o), 128'(mon_req));
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic step();
        @(posedge clock_i);
        #1;
    endtask

    task automatic accept_req(input addr_t addr);
        for (int i = 0; i < 20 && !bus.icacheReq_o; i++) step();
        if (!bus.icacheReq_o) chk("req_timeout", 128'd0, 128'd1);
        exp_req.push_back(addr);
        bus.icacheReady_i = 1'b1;
        step();
        bus.icacheReady_i = 1'b0;
    endtask

    task automatic respond(input bundle_t data);
        bus.icacheValid_i  = 1'b1;
        bus.icacheBundle_i = data;
        step();
        bus.icacheValid_i  = 1'b0;
    endtask

    task automatic expect_write(input bundle_t data, input addr_t pc);
        wr_t e;
        e.data = data;
        e.pc   = pc;
        exp_wr.push_back(e);
    endtask

    task automatic redirect(input addr_t addr, input logic with_valid);
        bus.redirect_i        = 1'b1;
        bus.redirectAddress_i = addr;
        bus.icacheValid_i     = with_valid;
        bus.icacheBundle_i    = {4{32'hDEADBEEF}};
        step();
        bus.redirect_i    = 1'b0;
        bus.icacheValid_i = 1'b0;
    endtask

    localparam bundle_t B_A = {32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC, 32'hDDDDDDDD};
    localparam bundle_t B_B = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    localparam bundle_t B_C = {32'h01234567, 32'h89ABCDEF, 32'hFEDCBA98, 32'h76543210};
    localparam bundle_t B_D = {32'h0000000D, 32'h1000000D, 32'h2000000D, 32'h3000000D};
    localparam bundle_t B_E = {32'hEEEEEEEE, 32'hEEEEEEEF, 32'hEEEEEEF0, 32'hEEEEEEF1};
    localparam bundle_t B_F = {32'hF0F0F0F0, 32'h0F0F0F0F, 32'hCAFEBABE, 32'h600DF00D};
    localparam bundle_t B_W = {32'h12345678, 32'h9ABCDEF0, 32'h0FEDCBA9, 32'h87654321};

    initial begin
        bus.redirect_i        = 1'b0;
        bus.redirectAddress_i = '0;
        bus.icacheReady_i     = 1'b0;
        bus.icacheValid_i     = 1'b0;
        bus.icacheBundle_i    = '0;
        bus.queueFull_i       = 1'b0;

        // Reset
        reset_i = 1'b1;
        repeat (2) step();
        reset_i = 1'b0;
        chk("reset_req",    128'(bus.icacheReq_o),   128'd0);
        chk("reset_write",  128'(bus.bundleWrite_o), 128'd0);
        chk("reset_bundle", bus.bundle_o,            128'd0);
        chk("reset_pc",     128'(bus.pc_o),          128'h100);
        step();
        chk("first_req", 128'(bus.icacheReq_o), 128'd1);

        // Plain fetch
        accept_req(64'h100);
        expect_write(B_A, 64'h110);
        respond(B_A);

        // Queue full for three cycles: bundle held, single write afterwards
        accept_req(64'h110);
        bus.queueFull_i = 1'b1;
        respond(B_B);
        repeat (2) step();
        expect_write(B_B, 64'h120);
        bus.queueFull_i = 1'b0;
        step();

        // Redirect in WAIT, stale response two cycles later
        accept_req(64'h120);
        redirect(64'h2000, 1'b0);
        step();
        respond(B_W);
        accept_req(64'h2000);

        // Redirect coinciding with the stale response
        redirect(64'h2000, 1'b1);
        accept_req(64'h2000);

        // Redirect in REQ to an unaligned target
        expect_write(B_C, 64'h2010);
        respond(B_C);
        redirect(64'h200C, 1'b0);
        accept_req(64'h2000);

        // PC wrap at the top of the address space
        expect_write(B_D, 64'h2010);
        respond(B_D);
        redirect(64'hFFFF_FFFF_FFFF_FFF0, 1'b0);
        accept_req(64'hFFFF_FFFF_FFFF_FFF0);
        expect_write(B_E, 64'h0);
        respond(B_E);
        accept_req(64'h0);

        // Reset while holding a bundle: it must never reach the queue
        bus.queueFull_i = 1'b1;
        respond({4{32'hEEEEEEEE}});
        step();
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
        bus.queueFull_i = 1'b0;
        chk("hold_reset_write", 128'(bus.bundleWrite_o), 128'd0);
        chk("hold_reset_pc",    128'(bus.pc_o),          128'h100);
        chk("hold_reset_bundle", bus.bundle_o,           128'd0);
        accept_req(64'h100);
        expect_write(B_F, 64'h110);
        respond(B_F);
        repeat (4) step();

        chk("writes_outstanding", 128'(exp_wr.size()),  128'd0);
        chk("reqs_outstanding",   128'(exp_req.size()), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
